// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/grant and response bundle for alu_share_arb.
// Ports: req/a/b/func per requester, gnt pulses, rsp valid/ready/id/out/zero, busy.
interface alu_share_arb_if #(
  parameter int SIZE = 32
);
  logic            req0;
  logic            req1;
  logic [SIZE-1:0] a0;
  logic [SIZE-1:0] b0;
  logic [SIZE-1:0] a1;
  logic [SIZE-1:0] b1;
  logic [2:0]      func0;
  logic [2:0]      func1;
  logic            gnt0;
  logic            gnt1;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [SIZE-1:0] rsp_out;
  logic            rsp_zero;
  logic            busy;

  modport master (
    output req0, req1, a0, b0, a1, b1, func0, func1, rsp_ready,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, func0, func1, rsp_ready,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_out, rsp_zero, busy
  );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one 32-bit ALU between two requesters (IDLE/EXEC/RESP).
// Ports: clk, rst (async high), bus (slave). Define ALU_SHARE_FIXED_PRI_EN for port-0 priority.
module alu_share_arb #(
  parameter int SIZE = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic [2:0]      f_q;
  logic            id_q;
  logic [SIZE-1:0] alu_y;
  logic            take;
  logic            pick1;

  assign take = bus.req0 | bus.req1;

`ifdef ALU_SHARE_FIXED_PRI_EN
  assign pick1 = bus.req1 & ~bus.req0;
`else
  logic last_id;

  // On a tie the port that was not granted last wins.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_id);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (state_q == IDLE && take) begin
      last_id <= pick1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_valid && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_y = '0;
    unique case (f_q)
      3'd0: alu_y = a_q + b_q;
      3'd1: alu_y = a_q - b_q;
      3'd2: alu_y = a_q & b_q;
      3'd3: alu_y = a_q | b_q;
      3'd4: alu_y = ~(a_q | b_q);
      3'd5: alu_y = {{(SIZE-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      3'd6: alu_y = '0;
      3'd7: alu_y = '0;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      f_q           <= '0;
      id_q          <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_out   <= '0;
      bus.rsp_zero  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            a_q      <= pick1 ? bus.a1 : bus.a0;
            b_q      <= pick1 ? bus.b1 : bus.b0;
            f_q      <= pick1 ? bus.func1 : bus.func0;
            id_q     <= pick1;
            bus.gnt0 <= ~pick1;
            bus.gnt1 <= pick1;
          end
        end
        EXEC: begin
          bus.gnt0      <= 1'b0;
          bus.gnt1      <= 1'b0;
          bus.rsp_out   <= alu_y;
          bus.rsp_zero  <= (alu_y == '0);
          bus.rsp_id    <= id_q;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: scoreboard bench for alu_share_arb.
// Drives both requesters through the bus interface and checks responses.
module tb_alu_share_arb;
  localparam int SIZE = 32;

  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_share_arb_if #(.SIZE(SIZE)) bus ();

  alu_share_arb #(.SIZE(SIZE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [31:0] o);
    exp_t x;
    x.id = id;
    x.out = o;
    x.zero = (o == 32'd0);
    sb.push_back(x);
  endtask

  task automatic get_exp(output exp_t x);
    if (sb.size() > 0) x = sb.pop_front();
    else x = '{id: 1'b1, out: 32'hDEAD_BEEF, zero: 1'b1};
  endtask

  task automatic idle_inputs;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.func0 = 0;
    bus.a1 = 0; bus.b1 = 0; bus.func1 = 0;
    bus.rsp_ready = 1;
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1;
    #3;
    total++;
    if (bus.gnt0 !== 0 || bus.gnt1 !== 0) begin
      bad++;
      $display("FAIL reset_gnt got %b%b want 00", bus.gnt0, bus.gnt1);
    end
    total++;
    if (bus.rsp_valid !== 0 || bus.busy !== 0) begin
      bad++;
      $display("FAIL reset_vb got v=%b b=%b want 0 0", bus.rsp_valid, bus.busy);
    end
    total++;
    if (bus.rsp_id !== 0 || bus.rsp_out !== 0 || bus.rsp_zero !== 0) begin
      bad++;
      $display("FAIL reset_rsp got id=%b out=%h z=%b want 0 0 0",
               bus.rsp_id, bus.rsp_out, bus.rsp_zero);
    end
    do_reset();
  endtask

  task automatic test_add;
    bus.req0 = 1; bus.a0 = 5; bus.b0 = 7; bus.func0 = 0;
    push(0, 32'd12);
    tick();
    total++;
    if (bus.gnt0 !== 1 || bus.gnt1 !== 0 || bus.rsp_valid !== 0) begin
      bad++;
      $display("FAIL add_gnt got g0=%b g1=%b v=%b want 1 0 0",
               bus.gnt0, bus.gnt1, bus.rsp_valid);
    end
    bus.req0 = 0;
    tick();
    total++;
    if (bus.gnt0 !== 0 || bus.rsp_valid !== 1) begin
      bad++;
      $display("FAIL add_valid got g0=%b v=%b want 0 1", bus.gnt0, bus.rsp_valid);
    end
    get_exp(e);
    total++;
    if (bus.rsp_id !== e.id || bus.rsp_out !== e.out || bus.rsp_zero !== e.zero) begin
      bad++;
      $display("FAIL add_rsp got id=%b out=%h z=%b want id=%b out=%h z=%b",
               bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 0 || bus.busy !== 0) begin
      bad++;
      $display("FAIL add_done got v=%b b=%b want 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_tie;
    do_reset();
    bus.req0 = 1; bus.a0 = 3; bus.b0 = 3; bus.func0 = 1;
    bus.req1 = 1; bus.a1 = 32'hF0; bus.b1 = 32'h0F; bus.func1 = 3;
    push(0, 32'd0);
    push(1, 32'hFF);
    tick();
    total++;
    if (bus.gnt0 !== 1 || bus.gnt1 !== 0) begin
      bad++;
      $display("FAIL tie_gnt0 got g0=%b g1=%b want 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
        bus.rsp_zero !== e.zero) begin
      bad++;
      $display("FAIL tie_rsp0 got v=%b id=%b out=%h z=%b want 1 %b %h %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
    end
    tick();
    total++;
    if (bus.gnt1 !== 0 || bus.rsp_valid !== 0) begin
      bad++;
      $display("FAIL tie_idle got g1=%b v=%b want 0 0", bus.gnt1, bus.rsp_valid);
    end
    tick();
    total++;
    if (bus.gnt1 !== 1 || bus.gnt0 !== 0) begin
      bad++;
      $display("FAIL tie_gnt1 got g0=%b g1=%b want 0 1", bus.gnt0, bus.gnt1);
    end
    bus.req1 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
        bus.rsp_zero !== e.zero) begin
      bad++;
      $display("FAIL tie_rsp1 got v=%b id=%b out=%h z=%b want 1 %b %h %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
    end
    tick();
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 0;
    bus.req0 = 1; bus.a0 = 1; bus.b0 = 2; bus.func0 = 0;
    bus.req1 = 1; bus.a1 = 32'hFF; bus.b1 = 32'h0F; bus.func1 = 2;
    push(0, 32'd3);
    push(1, 32'h0F);
    tick();
    total++;
    if (bus.gnt0 !== 1 || bus.gnt1 !== 0) begin
      bad++;
      $display("FAIL bp_gnt0 got g0=%b g1=%b want 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
        bus.rsp_zero !== e.zero) begin
      bad++;
      $display("FAIL bp_rsp0 got v=%b id=%b out=%h z=%b want 1 %b %h %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.rsp_valid !== 1 || bus.rsp_out !== e.out || bus.rsp_id !== e.id ||
          bus.gnt1 !== 0 || bus.busy !== 1) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got v=%b out=%h id=%b g1=%b b=%b want 1 %h %b 0 1",
                 i, bus.rsp_valid, bus.rsp_out, bus.rsp_id, bus.gnt1, bus.busy, e.out, e.id);
      end
    end
    bus.rsp_ready = 1;
    tick();
    total++;
    if (bus.rsp_valid !== 0 || bus.gnt1 !== 0) begin
      bad++;
      $display("FAIL bp_release got v=%b g1=%b want 0 0", bus.rsp_valid, bus.gnt1);
    end
    tick();
    total++;
    if (bus.gnt1 !== 1) begin
      bad++;
      $display("FAIL bp_gnt1 got %b want 1", bus.gnt1);
    end
    bus.req1 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
        bus.rsp_zero !== e.zero) begin
      bad++;
      $display("FAIL bp_rsp1 got v=%b id=%b out=%h z=%b want 1 %b %h %b",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
    end
    tick();
  endtask

  task automatic test_ops;
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [2:0]  tf [5];
    logic [31:0] ty [5];
    ta = '{32'hFFFF_FFFF, 32'd9, 32'd1, 32'd4, 32'd0};
    tb = '{32'd1, 32'd9, 32'hFFFF_FFFF, 32'd5, 32'd0};
    tf = '{3'd5, 3'd6, 3'd5, 3'd7, 3'd4};
    ty = '{32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      bus.req0 = 1; bus.a0 = ta[i]; bus.b0 = tb[i]; bus.func0 = tf[i];
      push(0, ty[i]);
      tick();
      bus.req0 = 0;
      tick();
      get_exp(e);
      total++;
      if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
          bus.rsp_zero !== e.zero) begin
        bad++;
        $display("FAIL op_%0d got v=%b id=%b out=%h z=%b want 1 %b %h %b",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, e.id, e.out, e.zero);
      end
      tick();
    end
  endtask

  task automatic test_reset_exec;
    bus.req0 = 1; bus.a0 = 1; bus.b0 = 1; bus.func0 = 0;
    tick();
    total++;
    if (bus.gnt0 !== 1 || bus.busy !== 1) begin
      bad++;
      $display("FAIL rx_gnt got g0=%b b=%b want 1 1", bus.gnt0, bus.busy);
    end
    bus.req0 = 0;
    #2;
    rst = 1;
    #1;
    total++;
    if (bus.gnt0 !== 0 || bus.gnt1 !== 0 || bus.rsp_valid !== 0 || bus.busy !== 0 ||
        bus.rsp_out !== 0 || bus.rsp_zero !== 0 || bus.rsp_id !== 0) begin
      bad++;
      $display("FAIL rx_async got g=%b%b v=%b b=%b out=%h z=%b id=%b want all 0",
               bus.gnt0, bus.gnt1, bus.rsp_valid, bus.busy, bus.rsp_out, bus.rsp_zero, bus.rsp_id);
    end
    tick();
    rst = 0;
    tick();
    total++;
    if (bus.rsp_valid !== 0 || bus.busy !== 0) begin
      bad++;
      $display("FAIL rx_norsp got v=%b b=%b want 0 0", bus.rsp_valid, bus.busy);
    end
    bus.req0 = 1; bus.a0 = 2; bus.b0 = 2; bus.func0 = 0;
    bus.req1 = 1; bus.a1 = 3; bus.b1 = 3; bus.func1 = 0;
    push(0, 32'd4);
    push(1, 32'd6);
    tick();
    total++;
    if (bus.gnt0 !== 1 || bus.gnt1 !== 0) begin
      bad++;
      $display("FAIL rx_first got g0=%b g1=%b want 1 0", bus.gnt0, bus.gnt1);
    end
    bus.req0 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out) begin
      bad++;
      $display("FAIL rx_rsp0 got v=%b id=%b out=%h want 1 %b %h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, e.id, e.out);
    end
    tick();
    tick();
    total++;
    if (bus.gnt1 !== 1) begin
      bad++;
      $display("FAIL rx_gnt1 got %b want 1", bus.gnt1);
    end
    bus.req1 = 0;
    tick();
    get_exp(e);
    total++;
    if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out) begin
      bad++;
      $display("FAIL rx_rsp1 got v=%b id=%b out=%h want 1 %b %h",
               bus.rsp_valid, bus.rsp_id, bus.rsp_out, e.id, e.out);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_p;
    int   w;
    do_reset();
    bus.rsp_ready = 1;
    bus.req0 = 1; bus.a0 = 10; bus.b0 = 3; bus.func0 = 0;
    bus.req1 = 1; bus.a1 = 10; bus.b1 = 3; bus.func1 = 1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!(bus.gnt0 || bus.gnt1) && w < 6);
      if (!(bus.gnt0 || bus.gnt1)) begin
        total++;
        bad++;
        $display("FAIL b2b_timeout op=%0d got no gnt want gnt", k);
        break;
      end
`ifdef ALU_SHARE_FIXED_PRI_EN
      exp_p = 1'b0;
`else
      exp_p = k[0];
`endif
      total++;
      if (bus.gnt1 !== exp_p || bus.gnt0 !== ~exp_p || bus.rsp_valid !== 0) begin
        bad++;
        $display("FAIL b2b_gnt op=%0d got g0=%b g1=%b v=%b want g1=%b v=0",
                 k, bus.gnt0, bus.gnt1, bus.rsp_valid, exp_p);
      end
      push(exp_p, exp_p ? 32'd7 : 32'd13);
      tick();
      get_exp(e);
      total++;
      if (bus.rsp_valid !== 1 || bus.rsp_id !== e.id || bus.rsp_out !== e.out ||
          bus.gnt0 !== 0 || bus.gnt1 !== 0) begin
        bad++;
        $display("FAIL b2b_rsp op=%0d got v=%b id=%b out=%h g=%b%b want 1 %b %h 00",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.gnt0, bus.gnt1, e.id, e.out);
      end
    end
    bus.req0 = 0;
    bus.req1 = 0;
    tick();
    tick();
    total++;
    if (sb.size() != 0 || bus.busy !== 0) begin
      bad++;
      $display("FAIL sb_empty got left=%0d busy=%b want 0 0", sb.size(), bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_tie();
    test_backpressure();
    test_ops();
    test_reset_exec();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
